// File: rtl/axis_pkt_gen_if.sv
// AXI4-Stream bundle between the packet generator and its sink.
interface axis_pkt_gen_if #(
    parameter int AXIS_WIDTH = 64
);
    logic [AXIS_WIDTH-1:0]   tdata;
    logic [AXIS_WIDTH/8-1:0] tstrb;
    logic                    tvalid;
    logic                    tready;
    logic                    tlast;

    modport master (output tdata, tstrb, tvalid, tlast, input tready);
    modport slave  (input tdata, tstrb, tvalid, tlast, output tready);
endinterface

// File: rtl/axis_pkt_gen.sv
// AXI4-Stream packet generator: N packets of length L with a (k+seq) byte pattern and a fixed gap.
// Optional PKT_GEN_SEQ_HDR_EN puts the 32-bit seq big-endian in bytes 0..3 (min length 4).
module axis_pkt_gen #(
    parameter int AXIS_WIDTH  = 64,
    parameter int MAX_PKT_LEN = 2048,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [CNT_W-1:0] pkt_len,
    input  logic [CNT_W-1:0] ipg,
    input  logic [CNT_W-1:0] num_pkts,
    axis_pkt_gen_if.master   axis,
    output logic             eos,
    output logic             busy,
    output logic [CNT_W-1:0] pkts_sent
);
    localparam int BYTES     = AXIS_WIDTH / 8;
    localparam int LEN_W     = $clog2(MAX_PKT_LEN + 1);
    localparam int MAX_BEATS = (MAX_PKT_LEN + BYTES - 1) / BYTES;
    localparam int BEAT_W    = (MAX_BEATS > 1) ? $clog2(MAX_BEATS) : 1;
`ifdef PKT_GEN_SEQ_HDR_EN
    localparam int MIN_LEN = 4;
    localparam int SEQ_W   = 32;
`else
    localparam int MIN_LEN = 1;
    localparam int SEQ_W   = 8;
`endif

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_LOAD = 3'd1;
    localparam logic [2:0] S_SEND = 3'd2;
    localparam logic [2:0] S_GAP  = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;

    typedef struct packed {
        logic [LEN_W-1:0] len;
        logic [CNT_W-1:0] ipg;
        logic [CNT_W-1:0] num;
    } cfg_t;

    logic [2:0]        state;
    cfg_t              cfg;
    logic [BEAT_W-1:0] beat;
    logic [BEAT_W-1:0] last_beat;
    logic [BYTES-1:0]  last_strb;
    logic [LEN_W-1:0]  base;       // absolute byte index of lane 0 in the current beat
    logic [CNT_W-1:0]  gap_cnt;
    logic [SEQ_W-1:0]  seq;

    logic [LEN_W-1:0]      len_clamp;
    logic [BYTES-1:0]      ld_strb;
    logic                  tvalid;
    logic                  is_last;
    logic                  hs;
    logic [BYTES-1:0]      strb;
    logic [AXIS_WIDTH-1:0] data;
    logic [CNT_W-1:0]      sent_nxt;

    always_comb begin
        if (32'(pkt_len) < MIN_LEN)
            len_clamp = LEN_W'(MIN_LEN);
        else if (32'(pkt_len) > MAX_PKT_LEN)
            len_clamp = LEN_W'(MAX_PKT_LEN);
        else
            len_clamp = LEN_W'(pkt_len);
    end

    // Last-beat strobe: low (L mod BYTES) lanes, or every lane when L is a whole number of beats.
    always_comb begin
        ld_strb = '0;
        for (int j = 0; j < BYTES; j++)
            ld_strb[j] = ((32'(cfg.len) % BYTES) == 0) || (32'(j) < (32'(cfg.len) % BYTES));
    end

    assign tvalid   = (state == S_SEND);
    assign is_last  = (beat == last_beat);
    assign hs       = tvalid && axis.tready;
    assign strb     = !tvalid ? '0 : (is_last ? last_strb : '1);
    assign sent_nxt = pkts_sent + CNT_W'(1);

    for (genvar j = 0; j < BYTES; j++) begin : g_byte
        logic [7:0] pat;
`ifdef PKT_GEN_SEQ_HDR_EN
        logic [LEN_W-1:0] k;
        logic [1:0]       hsel;
        assign k    = base + LEN_W'(j);
        assign hsel = 2'd3 - k[1:0];
        assign pat  = (k < LEN_W'(4)) ? seq[{hsel, 3'b000} +: 8] : k[7:0] + seq[7:0];
`else
        logic [7:0] k;
        assign k   = base[7:0] + 8'(j);
        assign pat = k + seq;
`endif
        assign data[8*j +: 8] = strb[j] ? pat : 8'h00;
    end

    assign axis.tvalid = tvalid;
    assign axis.tlast  = tvalid && is_last;
    assign axis.tstrb  = strb;
    assign axis.tdata  = data;
    assign eos         = (state == S_DONE);
    assign busy        = (state == S_LOAD) || (state == S_SEND) || (state == S_GAP);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            cfg       <= '0;
            beat      <= '0;
            last_beat <= '0;
            last_strb <= '0;
            base      <= '0;
            gap_cnt   <= '0;
            seq       <= '0;
            pkts_sent <= '0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        cfg       <= '{len: len_clamp, ipg: ipg, num: num_pkts};
                        pkts_sent <= '0;
                        seq       <= '0;
                        state     <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    last_beat <= BEAT_W'((32'(cfg.len) + BYTES - 1) / BYTES - 1);
                    last_strb <= ld_strb;
                    beat      <= '0;
                    base      <= '0;
                    state     <= S_SEND;
                end
                S_SEND: begin
                    if (hs) begin
                        if (is_last) begin
                            pkts_sent <= sent_nxt;
                            seq       <= seq + SEQ_W'(1);
                            beat      <= '0;
                            base      <= '0;
                            if (cfg.num != '0 && sent_nxt == cfg.num) begin
                                state <= S_DONE;
                            end else if (cfg.ipg != '0) begin
                                gap_cnt <= cfg.ipg;
                                state   <= S_GAP;
                            end
                        end else begin
                            beat <= beat + BEAT_W'(1);
                            base <= base + LEN_W'(BYTES);
                        end
                    end
                end
                S_GAP: begin
                    // Entered with gap_cnt = ipg >= 1, so exactly ipg idle cycles elapse.
                    gap_cnt <= gap_cnt - CNT_W'(1);
                    if (gap_cnt == CNT_W'(1))
                        state <= S_SEND;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: doc/axis_pkt_gen.md
Name: axis_pkt_gen

Overview:
- Synthesizable AXI4-Stream packet generator; sits directly upstream of the pcap dumper in network test benches and drives its tdata/tstrb/tvalid/tlast/eos inputs.
- Emits a programmed number of packets with programmable length, inter-packet gap and a deterministic byte pattern, so the resulting pcap can be checked byte-for-byte.
- Honours tready backpressure, so it can also feed DUTs that stall.

Parameters:
- AXIS_WIDTH, 64, data bus width in bits; multiple of 8, 8..512.
- MAX_PKT_LEN, 2048, largest packet length in bytes; longer requests are clamped.
- CNT_W, 16, width of the pkt_len, ipg, num_pkts and pkts_sent fields.

Ports:
- clk  input  1  clock.
- rst_n  input  1  reset, asynchronous, active-low.
- start  input  1  one-cycle pulse; latches configuration and begins a run (IDLE/DONE only).
- pkt_len  input  CNT_W  packet length in bytes.
- ipg  input  CNT_W  idle cycles between packets.
- num_pkts  input  CNT_W  packets per run; 0 = unlimited.
- tdata  output  AXIS_WIDTH  stream data, byte 0 in bits [7:0].
- tstrb  output  AXIS_WIDTH/8  byte qualifiers.
- tvalid  output  1  beat valid.
- tready  input  1  downstream ready.
- tlast  output  1  last beat of packet.
- eos  output  1  end of stream; high while in DONE.
- busy  output  1  high in LOAD/SEND/GAP.
- pkts_sent  output  CNT_W  completed packets this run; wraps modulo 2^CNT_W.

Behaviour:
- Reset (async, immediate, including mid-packet): tvalid=0, tlast=0, tdata=0, tstrb=0, eos=0, busy=0, pkts_sent=0, seq=0, state IDLE.
- States: IDLE, LOAD, SEND, GAP, DONE.
- IDLE/DONE + start: latch pkt_len, ipg and num_pkts, clear pkts_sent and seq, drop eos, go to LOAD. start in any other state is ignored.
- Length clamp: L = 1 if pkt_len==0; MAX_PKT_LEN if pkt_len>MAX_PKT_LEN; otherwise pkt_len.
- Beat count: B = ceil(L/BYTES), where BYTES = AXIS_WIDTH/8.
- LOAD: one cycle; computes B and the last-beat strobe. tvalid goes high on the next cycle (first beat), state SEND.
- Byte pattern: byte k of packet seq = (k + seq) mod 256.
- SEND: tvalid=1. tstrb is all-ones except on the last beat, where it is the low R bits set (R = L mod BYTES; R=0 means all ones). tlast=1 only on beat B.
- A beat advances only when tvalid && tready. While tvalid && !tready, tdata, tstrb and tlast hold stable.
- On the last-beat handshake: pkts_sent++ and seq++. Next state:
  - num_pkts!=0 and pkts_sent reaches num_pkts: DONE.
  - else if ipg==0: next packet's first beat is presented in the next cycle; tvalid stays high with no bubble.
  - else: GAP.
- GAP: tvalid=0 for exactly ipg cycles, then the first beat of the next packet.
- DONE: tvalid=0, eos=1 (single rising edge), busy=0. Remains until reset or start.
- tdata bytes with tstrb=0 are driven 0.
- Throughput: one beat per cycle with tready=1.

Optional Feature:
- Macro: PKT_GEN_SEQ_HDR_EN.
- Defined: bytes 0..3 of each packet carry the 32-bit seq, big-endian. The pattern applies from byte 4 onward, still computed with the absolute byte index k. Minimum clamped length is 4 (pkt_len<4 gives 4 bytes).
- Undefined: all bytes follow the pattern; minimum length is 1.

Test Plan:
- AXIS_WIDTH=64, pkt_len=64, ipg=0, num_pkts=1, tready=1 -> 8 beats, all tstrb=8'hFF, tlast on beat 8, beat 1 tdata=64'h0706050403020100, eos=1 the cycle after, pkts_sent=1.
- pkt_len=61, num_pkts=2, ipg=0 -> packet 0 is 8 beats with last tstrb=8'h1F. Packet 1 follows with no bubble; its first byte is 8'h01.
- pkt_len=24, tready alternating 1,0 each cycle -> tdata/tstrb/tlast stable during stalls, exactly 3 handshakes per packet, total byte count 24.
- pkt_len=8, ipg=5, num_pkts=3 -> exactly 5 tvalid=0 cycles between each tlast handshake and the next first beat; pkts_sent sequence 1,2,3; eos after the 3rd packet.
- Assert rst_n=0 on beat 3 of a 64-byte packet -> all outputs 0 asynchronously. Then start -> packet restarts at byte 0 with seq=0.
- pkt_len=0 -> 1 beat, tstrb=8'h01, tdata=0. pkt_len=4000 -> clamped to 2048, 256 beats, tlast only on beat 256.
